// File: rtl/clk_divider_pkg.sv
// Shared helpers for the clock divider slice: counter sizing and phase lengths.
package clk_divider_pkg;

    // Counter width for a modulo-div counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        int unsigned w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

    // Low-phase length in edges; odd ratios put the extra edge in the low phase.
    function automatic int unsigned lo_len(input int unsigned div);
        return div - div / 2;
    endfunction

endpackage

// File: rtl/clk_divider_if.sv
// Output bundle of the clock divider: divided clock plus its phase counter.
interface clk_divider_if #(
    parameter int unsigned CW = 4
);
    logic          clk_out;
    logic [CW-1:0] cnt;

    modport master (output clk_out, output cnt);
    modport slave  (input  clk_out, input  cnt);
endinterface

// File: rtl/clk_divider_mod_counter.sv
// Synchronous-reset modulo-MOD counter exposing its current and next value.
module mod_counter
    import clk_divider_pkg::*;
#(
    parameter  int unsigned MOD = 10,
    localparam int unsigned W   = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    if (MOD < 2) begin : g_bad_mod
        $error("mod_counter: MOD must be >= 2");
    end

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Explicit wrap compare, kept even when MOD is a power of two.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/clk_divider.sv
// Integer clock divider: clk_out is a registered square wave, LO edges low then HI edges high.
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic          clk_in,
    input  logic          rst,
    clk_divider_if.master out_if
);

    localparam int unsigned CW = cnt_width(DIV);
    localparam logic [CW-1:0] LO = CW'(lo_len(DIV));

    if (DIV < 2) begin : g_bad_div
        $error("clk_divider: DIV must be >= 2");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          clk_out_q;
    logic          clk_out_d;

    mod_counter #(
        .MOD (DIV)
    ) u_cnt (
        .clk     (clk_in),
        .rst     (rst),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt)
    );

    // Output level follows the counter value that will be loaded on this edge.
    always_comb begin
        clk_out_d = (cnt_nxt >= LO);
    end

    // Output flop; synchronous reset keeps clk_out low.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            clk_out_q <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
        end
    end

    assign out_if.clk_out = clk_out_q;
    assign out_if.cnt     = cnt;

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider at DIV = 10, 3, 2 and 16 sharing one clock and reset.
`timescale 1us / 1ns
module tb_clk_divider;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #500 clk_in = ~clk_in;

    clk_divider_if #(.CW(4)) if10 ();
    clk_divider_if #(.CW(2)) if3  ();
    clk_divider_if #(.CW(1)) if2  ();
    clk_divider_if #(.CW(4)) if16 ();

    clk_divider #(.DIV(10)) u_div10 (.clk_in(clk_in), .rst(rst), .out_if(if10));
    clk_divider #(.DIV(3))  u_div3  (.clk_in(clk_in), .rst(rst), .out_if(if3));
    clk_divider #(.DIV(2))  u_div2  (.clk_in(clk_in), .rst(rst), .out_if(if2));
    clk_divider #(.DIV(16)) u_div16 (.clk_in(clk_in), .rst(rst), .out_if(if16));

    // Advance one rising edge and settle well away from it before sampling.
    task automatic tick();
        @(posedge clk_in);
        #100;
    endtask

    // Reset for n edges, then release; the next tick is edge 1.
    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] outs;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            outs = {if16.clk_out, if2.clk_out, if3.clk_out, if10.clk_out};
            tests_run++;
            if (outs !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_clk_out edge %0d: got %b, want 0000", i, outs);
            end
            tests_run++;
            if ({if16.cnt, if2.cnt, if3.cnt, if10.cnt} !== 11'd0) begin
                tests_failed++;
                $display("FAIL reset_cnt edge %0d: got %h/%h/%h/%h, want all 0",
                         i, if10.cnt, if3.cnt, if2.cnt, if16.cnt);
            end
        end
    endtask

    task automatic test_div10_run();
        logic exp;
        logic prev;
        int   rises;
        do_reset(2);
        prev  = 1'b0;
        rises = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            // High on edges 5..9 of each 10-edge period.
            exp = ((k % 10) >= 5);
            tests_run++;
            if (if10.clk_out !== exp) begin
                tests_failed++;
                $display("FAIL div10_clk_out edge %0d: got %b, want %b", k, if10.clk_out, exp);
            end
            tests_run++;
            if (if10.cnt !== 4'(k % 10)) begin
                tests_failed++;
                $display("FAIL div10_cnt edge %0d: got %0d, want %0d", k, if10.cnt, k % 10);
            end
            if (if10.clk_out === 1'b1 && prev === 1'b0) rises++;
            prev = if10.clk_out;
        end
        tests_run++;
        if (rises !== 6) begin
            tests_failed++;
            $display("FAIL div10_rises: got %0d, want 6", rises);
        end
    endtask

    task automatic test_div10_mid_reset();
        logic exp;
        do_reset(1);
        for (int k = 1; k <= 7; k++) tick();
        tests_run++;
        if (if10.clk_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_pre: got %b, want 1", if10.clk_out);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (if10.clk_out !== 1'b0 || if10.cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_edge: got clk_out=%b cnt=%0d, want 0/0",
                     if10.clk_out, if10.cnt);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = (k == 5);
            tests_run++;
            if (if10.clk_out !== exp) begin
                tests_failed++;
                $display("FAIL mid_reset_restart edge %0d: got %b, want %b", k, if10.clk_out, exp);
            end
        end
    endtask

    task automatic test_div3();
        logic [2:0] pat;
        pat = 3'b100;  // indexed by edge mod 3: low, low, high
        do_reset(1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            tests_run++;
            if (if3.clk_out !== pat[k % 3]) begin
                tests_failed++;
                $display("FAIL div3_clk_out edge %0d: got %b, want %b", k, if3.clk_out, pat[k % 3]);
            end
            tests_run++;
            if (if3.cnt !== 2'(k % 3)) begin
                tests_failed++;
                $display("FAIL div3_cnt edge %0d: got %0d, want %0d", k, if3.cnt, k % 3);
            end
        end
    endtask

    task automatic test_div2();
        logic exp;
        do_reset(1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k % 2 == 1);
            tests_run++;
            if (if2.clk_out !== exp) begin
                tests_failed++;
                $display("FAIL div2_clk_out edge %0d: got %b, want %b", k, if2.clk_out, exp);
            end
        end
    endtask

    task automatic test_pow2();
        logic exp;
        logic prev;
        int   rises;
        int   falls;
        do_reset(1);
        prev  = 1'b0;
        rises = 0;
        falls = 0;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            exp = ((k % 16) >= 8);
            tests_run++;
            if (if16.clk_out !== exp || if16.cnt !== 4'(k % 16)) begin
                tests_failed++;
                $display("FAIL div16 edge %0d: got clk_out=%b cnt=%0d, want %b/%0d",
                         k, if16.clk_out, if16.cnt, exp, k % 16);
            end
            if (if16.clk_out === 1'b1 && prev === 1'b0) rises++;
            if (if16.clk_out === 1'b0 && prev === 1'b1) falls++;
            prev = if16.clk_out;
        end
        // Rises at edges 8, 24, ..., 1000; 62 complete periods end at edge 992.
        tests_run++;
        if (rises !== 63) begin
            tests_failed++;
            $display("FAIL div16_rises: got %0d, want 63", rises);
        end
        tests_run++;
        if (falls !== 62) begin
            tests_failed++;
            $display("FAIL div16_periods: got %0d, want 62", falls);
        end
    endtask

    initial begin
        test_reset();
        test_div10_run();
        test_div10_mid_reset();
        test_div3();
        test_div2();
        test_pow2();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
